// File: rtl/regfile_if.sv
// Register-file bus: WB write port, two ID read ports, debug read port and write counter.
interface regfile_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [ADDR_W-1:0] dbg_raddr_i;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic [31:0]       wr_count_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i, dbg_raddr_i,
    input  rdata1_o, rdata2_o, dbg_rdata_o, wr_count_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i, dbg_raddr_i,
    output rdata1_o, rdata2_o, dbg_rdata_o, wr_count_o
  );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: r0 hardwired to zero, one write port with
// same-cycle bypass to both read ports, plus an unbypassed debug port and write counter.
module regfile #(
  parameter int REG_NUM   = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int AW = $clog2(REG_NUM);

  logic [REG_WIDTH-1:0] regs [1:REG_NUM-1];
  logic [31:0]          wr_count;
  logic                 commit;
  logic [REG_WIDTH-1:0] rdata1;
  logic [REG_WIDTH-1:0] rdata2;
  logic [REG_WIDTH-1:0] dbg_rdata;

  assign commit = bus.we_i && (bus.waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[bus.waddr_i] <= bus.wdata_i;
    end
  end

  // Counts only writes that actually land in storage; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  // The bypass compares against the raw write address; addr 0 is filtered earlier,
  // so a dropped write to r0 can never leak through a read port.
  function automatic logic [REG_WIDTH-1:0] read_port(input logic re, input logic [AW-1:0] addr);
    logic [REG_WIDTH-1:0] value;
    value = '0;
    if (!rst && re && (addr != '0)) begin
      if (bus.we_i && (bus.waddr_i == addr)) begin
        value = bus.wdata_i;
      end else begin
        value = regs[addr];
      end
    end
    return value;
  endfunction

  always_comb begin
    rdata1 = read_port(bus.re1_i, bus.raddr1_i);
    rdata2 = read_port(bus.re2_i, bus.raddr2_i);
  end

  always_comb begin
    dbg_rdata = '0;
    if (!rst && (bus.dbg_raddr_i != '0)) begin
      dbg_rdata = regs[bus.dbg_raddr_i];
    end
  end

  assign bus.rdata1_o    = rdata1;
  assign bus.rdata2_o    = rdata2;
  assign bus.dbg_rdata_o = dbg_rdata;
  assign bus.wr_count_o  = rst ? 32'd0 : wr_count;
endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers with r0 hardwired to zero. It answers the two ID-stage read ports and accepts one write per cycle from write-back. Same-cycle write-to-read bypass is provided, so a WB-stage write is visible to ID in that cycle. ID's EX/MEM forwarding therefore only covers the two older in-flight stages. A debug read port and a committed-write counter are included for bench visibility.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (address width 5).
- REG_WIDTH, 32, register data width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high (rst==`RST_ENABLE).
- we_i  in  1  write enable from WB (`WR_ENABLE / `WR_DISABLE).
- waddr_i  in  5  write register address.
- wdata_i  in  32  write data.
- re1_i  in  1  read enable, port 1 (`RD_ENABLE / `RD_DISABLE), driven by ID re1_o.
- raddr1_i  in  5  read address, port 1 (ID raddr1_o / rs).
- rdata1_o  out  32  read data, port 1 (to ID rdata1_i).
- re2_i  in  1  read enable, port 2 (ID re2_o).
- raddr2_i  in  5  read address, port 2 (ID raddr2_o / rt).
- rdata2_o  out  32  read data, port 2 (to ID rdata2_i).
- dbg_raddr_i  in  5  debug read address.
- dbg_rdata_o  out  32  debug read data (stored value, no bypass).
- wr_count_o  out  32  count of committed writes since reset.

## Operation
- Storage: regs[1..31], 32 bits each. Register 0 is not stored and always reads as `ZERO_WORD.
- Write commit: on the rising clk edge where rst is deasserted, we_i==`WR_ENABLE and waddr_i!=0, regs[waddr_i] <= wdata_i and wr_count_o increments by 1.
  - Writes to address 0 are dropped and do not increment the counter.
- Read port n (n=1,2) is combinational, with priority:
  - rst asserted -> `ZERO_WORD.
  - re_n==`RD_DISABLE -> `ZERO_WORD.
  - raddr_n==0 -> `ZERO_WORD.
  - we_i==`WR_ENABLE and waddr_i==raddr_n -> wdata_i (bypass).
  - otherwise -> regs[raddr_n].
- Both read ports are independent. Both may address the same register, and both may hit the bypass in the same cycle.
- Debug port: dbg_rdata_o = (rst asserted or dbg_raddr_i==0) ? 0 : regs[dbg_raddr_i]. It returns the stored value only and reflects a write one cycle after commit.
- wr_count_o: 32-bit unsigned. It wraps from 0xFFFFFFFF to 0 with no flag.

## Timing
- Reset: asynchronous assertion immediately clears regs[1..31] and wr_count_o to 0. All data outputs read 0 while rst is asserted.
- An edge coinciding with rst asserted commits nothing.
- The first write can commit on the first rising edge after rst deasserts.
- Reset mid-operation discards all stored state; there is no partial retention.
- Write latency: 1 edge to storage, 0 cycles to read ports via bypass, 1 cycle to the debug port.
- No handshake and no stall: a write is accepted every cycle, and reads never block.
- Write and read of the same address in one cycle: the read returns the new data (bypass). The stored value updates at the edge.

## Test plan
- Reset: load r5=0x12345678, then assert rst asynchronously between edges -> rdata1_o, rdata2_o, dbg_rdata_o and wr_count_o are 0 immediately. After release, reading r5 returns 0.
- Basic write/read: write r3=0xDEADBEEF, next cycle re1_i=1, raddr1_i=3 -> rdata1_o=0xDEADBEEF, dbg_rdata_o (addr 3)=0xDEADBEEF, wr_count_o=1.
- Bypass: in one cycle we_i=1, waddr_i=7, wdata_i=0xA5A5A5A5, with both read ports on 7 (old r7=0x1) -> both read 0xA5A5A5A5 that cycle. dbg_rdata_o shows 0x1 that cycle and 0xA5A5A5A5 the next.
- r0 and enables: write r0=0xFFFFFFFF -> r0 reads 0 and wr_count_o is unchanged. With r4=0x55 and re2_i=0, raddr2_i=4 -> rdata2_o=0.
- Full sweep: write ri=i*0x01010101 for i=1..31 on consecutive cycles, then read all pairs on both ports -> every value matches and wr_count_o=31.
- Counter wrap: force 0xFFFFFFFF commits (or preload via hierarchical force), then one more write -> wr_count_o=0.
